// File: rtl/imem_fetch_unit.sv
// Instruction memory with a registered fetch/decode output stage, programmable wait states and PC tagging.
// Optional address fault detection is enabled by defining the macro IMEM_FAULT_EN.
module imem_fetch_unit #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter string       INIT_FILE   = "program.txt"
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [31:0] i_pc,
    input  logic        i_stall_decode,
    input  logic        i_flush_decode,
    output logic        o_busy,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid,
    output logic [1:0]  o_fault
);

    // state  | meaning
    // S_IDLE | ready to accept a fetch
    // S_WAIT | access in progress, cnt_q counts remaining wait states
    // S_DONE | access complete, parked while decode is stalled

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic [31:0]    opc_q, opc_d;
    logic           valid_q, valid_d;
    logic [1:0]     fault_q, fault_d;

    logic [31:0]    mem [DEPTH_WORDS];
    logic           accept;
    logic           do_load;
    logic [31:0]    ld_pc;
    logic [AW-1:0]  ld_idx;
    logic [1:0]     ld_fault;

    assign o_busy  = (state_q != S_IDLE) | i_stall_decode;
    // The flush cycle carries the redirect target, so it is taken even while an old access is in flight.
    assign accept  = i_req & (~o_busy | (i_flush_decode & ~i_stall_decode));

    // Zero-wait loads happen in IDLE straight from i_pc; multi-cycle loads use the latched address.
    assign ld_pc   = (state_q == S_IDLE) ? i_pc : pc_q;
    assign ld_idx  = ld_pc[AW+1:2];

`ifdef IMEM_FAULT_EN
    assign ld_fault = {(ld_pc[31:2] >= 30'(DEPTH_WORDS)), (ld_pc[1:0] != 2'b00)};
`else
    assign ld_fault = 2'b00;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        fault_d = fault_q;
        do_load = 1'b0;

        if (i_stall_decode) begin
            if (state_q == S_WAIT) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
        end else begin
            // Anything not loaded this edge leaves a bubble in decode.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            fault_d = 2'b00;

            if (i_flush_decode) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_WAIT: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            do_load = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_DONE: begin
                        do_load = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            if (accept) begin
                pc_d = i_pc;
                if (WAIT_CYCLES == 0) begin
                    do_load = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                end
            end

            if (do_load) begin
                instr_d = (ld_fault != 2'b00) ? NOP_INSTR : mem[ld_idx];
                opc_d   = ld_pc;
                valid_d = 1'b1;
                fault_d = ld_fault;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            opc_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign o_instr = instr_q;
    assign o_pc    = opc_q;
    assign o_valid = valid_q;
    assign o_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: a zero-wait and a three-wait instance share the stimulus and are
// compared every cycle against a timestamp-based fetch model; IMEM_FAULT_EN selects fault expectations.
module tb_imem_fetch_unit;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   = 1'b0;
    logic [31:0] pc    = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        busy_a  [2];
    logic [31:0] instr_a [2];
    logic [31:0] opc_a   [2];
    logic        valid_a [2];
    logic [1:0]  fault_a [2];

    logic [31:0] img [DEPTH];
    int          wc [2] = '{0, 3};

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state: a pending fetch becomes deliverable at absolute edge m_due
    bit          m_pend  [2];
    logic [31:0] m_ppc   [2];
    int          m_due   [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc    [2];
    bit          m_valid [2];
    logic [1:0]  m_fault [2];
    bit          m_acc;
    int          ecnt = 0;

    always #5 clk = ~clk;

    imem_fetch_unit #(
        .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .NOP_INSTR(NOP), .INIT_FILE("")
    ) u0 (
        .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_pc(pc),
        .i_stall_decode(stall), .i_flush_decode(flush),
        .o_busy(busy_a[0]), .o_instr(instr_a[0]), .o_pc(opc_a[0]),
        .o_valid(valid_a[0]), .o_fault(fault_a[0])
    );

    imem_fetch_unit #(
        .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .NOP_INSTR(NOP), .INIT_FILE("")
    ) u3 (
        .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_pc(pc),
        .i_stall_decode(stall), .i_flush_decode(flush),
        .o_busy(busy_a[1]), .o_instr(instr_a[1]), .o_pc(opc_a[1]),
        .o_valid(valid_a[1]), .o_fault(fault_a[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic deliver(input int d, input logic [31:0] a);
        m_pc[d]    = a;
        m_valid[d] = 1'b1;
`ifdef IMEM_FAULT_EN
        m_fault[d] = {((a >> 2) >= 32'(DEPTH)), ((a % 4) != 0)};
`else
        m_fault[d] = 2'b00;
`endif
        m_instr[d] = (m_fault[d] != 2'b00) ? NOP : img[(a >> 2) % DEPTH];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_pend[d]  = 1'b0;
                m_instr[d] = NOP;
                m_pc[d]    = '0;
                m_valid[d] = 1'b0;
                m_fault[d] = 2'b00;
            end
        end else begin
            ecnt++;
            for (int d = 0; d < 2; d++) begin
                m_acc = req && (!(m_pend[d] || stall) || (flush && !stall));
                if (!stall) begin
                    m_instr[d] = NOP;
                    m_valid[d] = 1'b0;
                    m_fault[d] = 2'b00;
                    if (flush) begin
                        m_pend[d] = 1'b0;
                    end else if (m_pend[d] && ecnt >= m_due[d]) begin
                        deliver(d, m_ppc[d]);
                        m_pend[d] = 1'b0;
                    end
                    if (m_acc) begin
                        if (wc[d] == 0) begin
                            deliver(d, pc);
                        end else begin
                            m_pend[d] = 1'b1;
                            m_ppc[d]  = pc;
                            m_due[d]  = ecnt + wc[d];
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check(d == 0 ? "w0 instr" : "w3 instr", instr_a[d], m_instr[d]);
                check(d == 0 ? "w0 pc"    : "w3 pc",    opc_a[d],   m_pc[d]);
                check(d == 0 ? "w0 valid" : "w3 valid", 32'(valid_a[d]), 32'(m_valid[d]));
                check(d == 0 ? "w0 fault" : "w3 fault", 32'(fault_a[d]), 32'(m_fault[d]));
                check(d == 0 ? "w0 busy"  : "w3 busy",  32'(busy_a[d]),
                      32'(m_pend[d] || stall));
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) img[i] = 32'hC0DE_0000 + 32'(i);
        img[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < DEPTH; i++) begin
            u0.mem[i] = img[i];
            u3.mem[i] = img[i];
        end

        #1 rst_n = 1'b0;
        #1;
        check("rst instr", instr_a[0], NOP);
        check("rst valid", 32'(valid_a[0]), 32'd0);
        check("rst pc", opc_a[1], 32'd0);
        check("rst busy", 32'(busy_a[1]), 32'd0);
        chk_en = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // single fetch of pc=4
        req = 1'b1; pc = 32'd4;
        step();
        req = 1'b0;
        check("w0 first instr", instr_a[0], 32'hDEAD_BEEF);
        check("w0 first pc", opc_a[0], 32'd4);
        check("w0 first valid", 32'(valid_a[0]), 32'd1);
        check("w0 first busy", 32'(busy_a[0]), 32'd0);
        check("w3 busy e0", 32'(busy_a[1]), 32'd1);
        step();
        check("w3 busy e1", 32'(busy_a[1]), 32'd1);
        step();
        check("w3 busy e2", 32'(busy_a[1]), 32'd1);
        step();
        check("w3 data", instr_a[1], 32'hDEAD_BEEF);
        check("w3 data pc", opc_a[1], 32'd4);
        check("w3 busy done", 32'(busy_a[1]), 32'd0);

        // back-to-back on the zero-wait instance
        req = 1'b1; pc = 32'd0;
        step();
        check("w0 b2b 0", instr_a[0], 32'hC0DE_0000);
        pc = 32'd8;
        step();
        check("w0 b2b 8", instr_a[0], 32'hC0DE_0002);
        pc = 32'd12;
        step();
        check("w0 b2b 12 pc", opc_a[0], 32'd12);
        req = 1'b0;
        repeat (4) step();

        // stall parks the wait-state fetch; a flush under stall is ignored
        req = 1'b1; pc = 32'd8;
        step();
        req = 1'b0; stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            flush = (i == 2);
            step();
        end
        flush = 1'b0;
        check("w0 held instr", instr_a[0], 32'hC0DE_0002);
        check("w0 held valid", 32'(valid_a[0]), 32'd1);
        check("w3 parked valid", 32'(valid_a[1]), 32'd0);
        stall = 1'b0;
        step();
        check("w3 unpark instr", instr_a[1], 32'hC0DE_0002);
        check("w3 unpark pc", opc_a[1], 32'd8);
        step();

        // flush during WAIT with redirect to 0x40
        req = 1'b1; pc = 32'h10;
        step();
        flush = 1'b1; pc = 32'h40;
        step();
        flush = 1'b0; req = 1'b0;
        check("w3 flushed valid", 32'(valid_a[1]), 32'd0);
        step();
        step();
        check("w3 old dropped", 32'(valid_a[1]), 32'd0);
        step();
        check("w3 redirect pc", opc_a[1], 32'h40);
        check("w3 redirect instr", instr_a[1], 32'hC0DE_0010);
        step();

        // misaligned and out-of-range addresses
        req = 1'b1; pc = 32'h6;
        step();
`ifdef IMEM_FAULT_EN
        check("w0 misalign fault", 32'(fault_a[0]), 32'h1);
        check("w0 misalign instr", instr_a[0], NOP);
`else
        check("w0 misalign fault", 32'(fault_a[0]), 32'h0);
        check("w0 misalign instr", instr_a[0], 32'hDEAD_BEEF);
`endif
        pc = 32'(DEPTH * 4);
        step();
        req = 1'b0;
`ifdef IMEM_FAULT_EN
        check("w0 range fault", 32'(fault_a[0]), 32'h2);
        check("w0 range instr", instr_a[0], NOP);
        check("w0 range valid", 32'(valid_a[0]), 32'd1);
`else
        check("w0 range fault", 32'(fault_a[0]), 32'h0);
        check("w0 range instr", instr_a[0], 32'hC0DE_0000);
`endif
        repeat (4) step();

        // reset in the middle of a wait-state access
        req = 1'b1; pc = 32'd12;
        step();
        req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("w3 rst busy", 32'(busy_a[1]), 32'd0);
        check("w3 rst instr", instr_a[1], NOP);
        check("w3 rst pc", opc_a[1], 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("w3 nothing delivered", 32'(valid_a[1]), 32'd0);

        // reset while decode is stalled
        req = 1'b1; pc = 32'd4;
        step();
        req = 1'b0; stall = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check("w0 rst stall instr", instr_a[0], NOP);
        check("w0 rst stall valid", 32'(valid_a[0]), 32'd0);
        step();
        rst_n = 1'b1; stall = 1'b0;
        step();
        check("w0 busy after rst", 32'(busy_a[0]), 32'd0);
        check("w3 busy after rst", 32'(busy_a[1]), 32'd0);
        repeat (2) step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
